// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic inter-stage pipeline register with a valid/ready
//               handshake, an optional 2-entry skid buffer (registered
//               o_ready), a synchronous bubble-inserting flush and
//               saturating stall/flush statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 128,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID      = 1'b1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_INC = {{(CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Storage / handshake core
  // --------------------------------------------------------------------------
  generate
    if (SKID) begin : g_skid
      // Occupancy doubles as the state encoding so o_occupancy is the state.
      typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
      } state_t;

      state_t            r_state;
      state_t            w_state_nxt;
      logic [DATA_W-1:0] r_main;
      logic [DATA_W-1:0] r_skid;
      logic [DATA_W-1:0] w_main_nxt;
      logic [DATA_W-1:0] w_skid_nxt;
      logic              r_ready;
      logic              w_ready_nxt;
      logic              w_accept;
      logic              w_emit;

      // o_ready comes from a flop, so upstream never sees i_ready combinationally.
      assign w_accept = i_valid & r_ready;
      assign w_emit   = (r_state != ST_EMPTY) & i_ready;

      // State register.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_state <= ST_EMPTY;
        end else begin
          r_state <= w_state_nxt;
        end
      end

      // Next-state and next-payload selection; flush forces an empty stage.
      always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (i_flush) begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = RESET_VAL;
          w_skid_nxt  = RESET_VAL;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              if (w_accept) begin
                w_state_nxt = ST_BUSY;
                w_main_nxt  = i_data;
              end
            end
            ST_BUSY: begin
              if (w_accept && w_emit) begin
                w_main_nxt  = i_data;
              end else if (w_accept) begin
                w_state_nxt = ST_FULL;
                w_skid_nxt  = i_data;
              end else if (w_emit) begin
                w_state_nxt = ST_EMPTY;
                w_main_nxt  = RESET_VAL;
              end
            end
            ST_FULL: begin
              if (w_emit) begin
                w_state_nxt = ST_BUSY;
                w_main_nxt  = r_skid;
                w_skid_nxt  = RESET_VAL;
              end
            end
            default: begin
              w_state_nxt = ST_EMPTY;
              w_main_nxt  = RESET_VAL;
              w_skid_nxt  = RESET_VAL;
            end
          endcase
        end
        w_ready_nxt = (w_state_nxt != ST_FULL);
      end

      // Payload registers and registered ready.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_main  <= RESET_VAL;
          r_skid  <= RESET_VAL;
          r_ready <= 1'b1;
        end else begin
          r_main  <= w_main_nxt;
          r_skid  <= w_skid_nxt;
          r_ready <= w_ready_nxt;
        end
      end

      // r_main is forced to RESET_VAL whenever the stage empties, so it can
      // drive o_data directly without leaking stale payload.
      assign o_valid     = (r_state != ST_EMPTY);
      assign o_data      = r_main;
      assign o_ready     = r_ready;
      assign o_occupancy = r_state;
    end else begin : g_single
      logic              r_valid;
      logic [DATA_W-1:0] r_data;
      logic              w_ready;
      logic              w_accept;
      logic              w_emit;

      // Combinational ready: free slot, or the held beat leaves this cycle.
      assign w_ready  = ~r_valid | i_ready;
      assign w_accept = i_valid & w_ready;
      assign w_emit   = r_valid & i_ready;

      // Single holding register; empties to RESET_VAL on emit or flush.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_valid <= 1'b0;
          r_data  <= RESET_VAL;
        end else if (i_flush) begin
          r_valid <= 1'b0;
          r_data  <= RESET_VAL;
        end else if (w_accept) begin
          r_valid <= 1'b1;
          r_data  <= i_data;
        end else if (w_emit) begin
          r_valid <= 1'b0;
          r_data  <= RESET_VAL;
        end
      end

      assign o_valid     = r_valid;
      assign o_data      = r_data;
      assign o_ready     = w_ready;
      assign o_occupancy = {1'b0, r_valid};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  logic             w_stall_evt;
  logic             w_flush_evt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_stall_evt = o_valid & ~i_ready;
  assign w_flush_evt = i_flush & (o_occupancy != 2'd0);

  // Saturating counters; only reset clears them.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_INC;
      end
      if (w_flush_evt && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + c_CNT_INC;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg (skid,
//               single-register and narrow-counter configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  // Skid configuration, 32-bit payload.
  logic        a_flush, a_valid, a_rdy_in, a_ovalid, a_ordy;
  logic [31:0] a_data, a_odata;
  logic [1:0]  a_occ;
  logic [15:0] a_stall, a_fcnt;

  // Single-register configuration.
  logic        b_flush, b_valid, b_rdy_in, b_ovalid, b_ordy;
  logic [31:0] b_data, b_odata;
  logic [1:0]  b_occ;
  logic [15:0] b_stall, b_fcnt;

  // Skid configuration with 4-bit counters.
  logic        c_flush, c_valid, c_rdy_in, c_ovalid, c_ordy;
  logic [31:0] c_data, c_odata;
  logic [1:0]  c_occ;
  logic [3:0]  c_stall, c_fcnt;

  pipe_stage_reg #(.DATA_W(32), .RESET_VAL(32'h0), .SKID(1'b1), .CNT_W(16)) u_dut_a (
    .i_clk(clk), .i_reset(rst), .i_flush(a_flush), .i_valid(a_valid), .o_ready(a_ordy),
    .i_data(a_data), .o_valid(a_ovalid), .i_ready(a_rdy_in), .o_data(a_odata),
    .o_occupancy(a_occ), .o_stall_cnt(a_stall), .o_flush_cnt(a_fcnt)
  );

  pipe_stage_reg #(.DATA_W(32), .RESET_VAL(32'h0), .SKID(1'b0), .CNT_W(16)) u_dut_b (
    .i_clk(clk), .i_reset(rst), .i_flush(b_flush), .i_valid(b_valid), .o_ready(b_ordy),
    .i_data(b_data), .o_valid(b_ovalid), .i_ready(b_rdy_in), .o_data(b_odata),
    .o_occupancy(b_occ), .o_stall_cnt(b_stall), .o_flush_cnt(b_fcnt)
  );

  pipe_stage_reg #(.DATA_W(32), .RESET_VAL(32'h0), .SKID(1'b1), .CNT_W(4)) u_dut_c (
    .i_clk(clk), .i_reset(rst), .i_flush(c_flush), .i_valid(c_valid), .o_ready(c_ordy),
    .i_data(c_data), .o_valid(c_ovalid), .i_ready(c_rdy_in), .o_data(c_odata),
    .o_occupancy(c_occ), .o_stall_cnt(c_stall), .o_flush_cnt(c_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst = 1'b1;
    a_flush = 0; a_valid = 0; a_rdy_in = 0; a_data = '0;
    b_flush = 0; b_valid = 0; b_rdy_in = 0; b_data = '0;
    c_flush = 0; c_valid = 0; c_rdy_in = 0; c_data = '0;
    #2;
    chk("rst_valid", 64'(a_ovalid), 64'h0);
    chk("rst_data",  64'(a_odata),  64'h0);
    chk("rst_occ",   64'(a_occ),    64'h0);
    chk("rst_ready", 64'(a_ordy),   64'h1);
    chk("rst_stall", 64'(a_stall),  64'h0);
    chk("rst_fcnt",  64'(a_fcnt),   64'h0);
    step();
    rst = 1'b0;

    // ---- streaming with downstream always ready ----
    a_rdy_in = 1; a_valid = 1; a_data = 32'h11;
    step();
    chk("t1_d11", 64'(a_odata), 64'h11); chk("t1_v11", 64'(a_ovalid), 64'h1);
    chk("t1_r11", 64'(a_ordy), 64'h1);
    a_data = 32'h22;
    step();
    chk("t1_d22", 64'(a_odata), 64'h22); chk("t1_v22", 64'(a_ovalid), 64'h1);
    chk("t1_occ22", 64'(a_occ), 64'h1);
    a_data = 32'h33;
    step();
    chk("t1_d33", 64'(a_odata), 64'h33); chk("t1_r33", 64'(a_ordy), 64'h1);
    a_valid = 0;
    step();
    chk("t1_drain_v", 64'(a_ovalid), 64'h0); chk("t1_drain_d", 64'(a_odata), 64'h0);
    chk("t1_stall", 64'(a_stall), 64'h0);

    // ---- back-pressure fills the skid entry ----
    a_rdy_in = 0; a_valid = 1; a_data = 32'hA1;
    step();
    chk("t2_busy_d", 64'(a_odata), 64'hA1); chk("t2_busy_r", 64'(a_ordy), 64'h1);
    chk("t2_busy_occ", 64'(a_occ), 64'h1);
    a_data = 32'hA2;
    step();
    chk("t2_full_occ", 64'(a_occ), 64'h2); chk("t2_full_r", 64'(a_ordy), 64'h0);
    chk("t2_full_d", 64'(a_odata), 64'hA1);
    a_data = 32'hA3;
    step();
    chk("t2_hold_occ", 64'(a_occ), 64'h2); chk("t2_hold_d", 64'(a_odata), 64'hA1);
    chk("t2_hold_stall", 64'(a_stall), 64'h2);
    a_rdy_in = 1;
    step();
    chk("t2_out_a2", 64'(a_odata), 64'hA2); chk("t2_out_a2_occ", 64'(a_occ), 64'h1);
    chk("t2_out_a2_r", 64'(a_ordy), 64'h1);
    step();
    chk("t2_out_a3", 64'(a_odata), 64'hA3); chk("t2_out_a3_v", 64'(a_ovalid), 64'h1);
    a_valid = 0;
    step();
    chk("t2_empty", 64'(a_ovalid), 64'h0); chk("t2_stall", 64'(a_stall), 64'h2);

    // ---- flush while full, with a beat on offer ----
    a_rdy_in = 0; a_valid = 1; a_data = 32'hB1;
    step();
    a_data = 32'hB2;
    step();
    chk("t3_full", 64'(a_occ), 64'h2);
    a_flush = 1; a_data = 32'hB3;
    step();
    chk("t3_v", 64'(a_ovalid), 64'h0); chk("t3_d", 64'(a_odata), 64'h0);
    chk("t3_occ", 64'(a_occ), 64'h0); chk("t3_r", 64'(a_ordy), 64'h1);
    chk("t3_fcnt", 64'(a_fcnt), 64'h1);
    a_valid = 0;
    step();
    chk("t3_fcnt_empty", 64'(a_fcnt), 64'h1); chk("t3_v2", 64'(a_ovalid), 64'h0);
    a_flush = 0; a_rdy_in = 1;
    step();
    chk("t3_no_b3", 64'(a_ovalid), 64'h0); chk("t3_stall", 64'(a_stall), 64'h4);

    // ---- asynchronous reset mid-stream ----
    a_rdy_in = 0; a_valid = 1; a_data = 32'hC1;
    step();
    chk("t4_busy", 64'(a_odata), 64'hC1);
    a_valid = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("t4_async_v", 64'(a_ovalid), 64'h0); chk("t4_async_d", 64'(a_odata), 64'h0);
    chk("t4_async_stall", 64'(a_stall), 64'h0); chk("t4_async_fcnt", 64'(a_fcnt), 64'h0);
    step();
    rst = 1'b0;
    a_rdy_in = 1; a_valid = 1; a_data = 32'hC2;
    step();
    chk("t4_c2_d", 64'(a_odata), 64'hC2); chk("t4_c2_v", 64'(a_ovalid), 64'h1);
    a_valid = 0;
    step();
    chk("t4_c2_gone", 64'(a_ovalid), 64'h0);

    // ---- single-register mode with toggling downstream ready ----
    b_valid = 1; b_data = 32'hD1; b_rdy_in = 1;
    #1;
    chk("t5_rdy0", 64'(b_ordy), 64'h1);
    step();
    chk("t5_d1", 64'(b_odata), 64'hD1); chk("t5_occ1", 64'(b_occ), 64'h1);
    b_data = 32'hD2; b_rdy_in = 0;
    #1;
    chk("t5_rdy1", 64'(b_ordy), 64'h0);
    step();
    chk("t5_hold_d1", 64'(b_odata), 64'hD1); chk("t5_hold_occ", 64'(b_occ), 64'h1);
    b_rdy_in = 1;
    #1;
    chk("t5_rdy2", 64'(b_ordy), 64'h1);
    step();
    chk("t5_d2", 64'(b_odata), 64'hD2);
    b_data = 32'hD3;
    step();
    chk("t5_d3", 64'(b_odata), 64'hD3); chk("t5_occ3", 64'(b_occ), 64'h1);
    b_valid = 0;
    step();
    chk("t5_empty_v", 64'(b_ovalid), 64'h0); chk("t5_empty_d", 64'(b_odata), 64'h0);
    chk("t5_stall", 64'(b_stall), 64'h1);

    // ---- stall counter saturation (4-bit) ----
    c_rdy_in = 0; c_valid = 1; c_data = 32'h5;
    step();
    c_valid = 0;
    for (int i = 0; i < 10; i++) step();
    chk("t6_stall10", 64'(c_stall), 64'hA);
    for (int i = 0; i < 10; i++) step();
    chk("t6_stall_sat", 64'(c_stall), 64'hF);
    chk("t6_hold_d", 64'(c_odata), 64'h5);
    step();
    chk("t6_stall_sat2", 64'(c_stall), 64'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
